// File: rtl/df_serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), LSB first, WIDTH cycles per result.
// Optional output clamp on signed overflow when DF_SUB_SATURATE_EN is defined.
module df_serial_subtractor #(
    parameter int WIDTH = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             ovf_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    // Full-subtractor cell: two half-subtractor stages feeding one borrow register.
    logic             hs1_d, hs1_b;
    logic             d_bit, hs2_b, br_next;
    logic             ovf_next;
    logic [WIDTH-1:0] res_full;
    logic [WIDTH-1:0] final_res;

    assign hs1_d   = a_sh_q[0] ^ b_sh_q[0];
    assign hs1_b   = ~a_sh_q[0] & b_sh_q[0];
    assign d_bit   = hs1_d ^ br_q;
    assign hs2_b   = ~hs1_d & br_q;
    assign br_next = hs1_b | hs2_b;

    // On the final edge the shifters hold the operand MSBs in bit 0.
    assign ovf_next = (a_sh_q[0] ^ b_sh_q[0]) & (a_sh_q[0] ^ d_bit);
    assign res_full = {d_bit, res_q};

`ifdef DF_SUB_SATURATE_EN
    logic [WIDTH-1:0] sat_val;
    assign sat_val   = a_sh_q[0] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign final_res = ovf_next ? sat_val : res_full;
`else
    assign final_res = res_full;
`endif

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_full[WIDTH-1:1];
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d  = ST_DONE;
                    diff_d   = final_res;
                    borrow_d = br_next;
                    ovf_d    = ovf_next;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy_o   = (state_q == ST_SHIFT);
    assign done_o   = (state_q == ST_DONE);
    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_df_serial_subtractor.sv
// Directed self-checking bench for df_serial_subtractor at WIDTH=8.
// Expected diffs follow DF_SUB_SATURATE_EN when the bench is built with it.
module tb_df_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, borrow, ovf;
    logic [W-1:0] diff;

    int total = 0;
    int bad   = 0;

    df_serial_subtractor #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .busy_o  (busy),
        .done_o  (done),
        .diff_o  (diff),
        .borrow_o(borrow),
        .ovf_o   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the accepting edge until done rises (bounded).
    task automatic wait_done(input string tag, input logic [W-1:0] hold_diff, output int n);
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            tick();
            n++;
            if (n == 4) chk({tag, "_diff_stable"}, diff, hold_diff);
        end
        chk({tag, "_latency"}, n, 8);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
        logic [W-1:0] prev;
        int n;
        prev  = diff;
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
        chk({tag, "_busy"}, busy, 1);
        wait_done(tag, prev, n);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_borrow"}, borrow, eb);
        chk({tag, "_ovf"}, ovf, eo);
        chk({tag, "_busy_in_done"}, busy, 0);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_diff_held"}, diff, ed);
    endtask

    initial begin
        logic [W-1:0] sat3, sat4, sat5;
        int n;
        int seen;
`ifdef DF_SUB_SATURATE_EN
        sat3 = 8'h80; sat4 = 8'h7F; sat5 = 8'h7F;
`else
        sat3 = 8'h7F; sat4 = 8'h80; sat5 = 8'h80;
`endif
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        tick();

        run_op("t1", 8'd100, 8'd58, 8'h2A, 1'b0, 1'b0);
        run_op("t2", 8'd5,   8'd7,  8'hFE, 1'b1, 1'b0);
        run_op("t3", 8'h80,  8'h01, sat3,  1'b0, 1'b1);
        run_op("t4", 8'h7F,  8'hFF, sat4,  1'b1, 1'b1);
        run_op("zero", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op("neg_min", 8'h00, 8'h80, sat5, 1'b1, 1'b1);
        run_op("same_neg", 8'h80, 8'h80, 8'h00, 1'b0, 1'b0);

        // Start held high with new operands during SHIFT; back-to-back accept from DONE.
        a     = 8'd100;
        b     = 8'd58;
        start = 1'b1;
        tick();
        a     = 8'd5;
        b     = 8'd7;
        chk("t5_busy", busy, 1);
        wait_done("t5a", 8'h00, n);
        chk("t5a_diff", diff, 8'h2A);
        chk("t5a_borrow", borrow, 0);
        tick();
        start = 1'b0;
        chk("t5_reaccept_busy", busy, 1);
        chk("t5_reaccept_done", done, 0);
        wait_done("t5b", 8'h2A, n);
        chk("t5b_diff", diff, 8'hFE);
        chk("t5b_borrow", borrow, 1);
        chk("t5b_ovf", ovf, 0);
        tick();
        chk("t5b_done_pulse", done, 0);

        // Abort by reset on the 4th SHIFT edge.
        a     = 8'h33;
        b     = 8'h11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_diff", diff, 0);
        chk("t6_borrow", borrow, 0);
        chk("t6_ovf", ovf, 0);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        chk("t6_no_done", seen, 0);

        run_op("post_rst", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
